// File: rtl/jtkunio_bram_sdram.sv
`default_nettype none
// ============================================================================
//  Module   : jtkunio_bram_sdram
//  Purpose  : Block-RAM stand-in for the four-bank SDRAM request interface
//             and the ROM-download (prog) port. It uses the same
//             ack/dst/dok/rdy handshake as the real controller.
//  Revision : 1.0  initial release
// ============================================================================
module jtkunio_bram_sdram #(
    parameter int AW    = 15,
    parameter int LAT   = 2,
    parameter int BURST = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] ba0_addr,
    input  logic [21:0] ba1_addr,
    input  logic [21:0] ba2_addr,
    input  logic [21:0] ba3_addr,
    input  logic [3:0]  ba_rd,
    input  logic        ba_wr,
    input  logic [15:0] ba0_din,
    input  logic [1:0]  ba0_din_m,
    output logic [3:0]  ba_ack,
    output logic [3:0]  ba_dst,
    output logic [3:0]  ba_dok,
    output logic [3:0]  ba_rdy,
    output logic [15:0] data_read,
    input  logic [21:0] prog_addr,
    input  logic [15:0] prog_data,
    input  logic [1:0]  prog_mask,
    input  logic [1:0]  prog_ba,
    input  logic        prog_we,
    input  logic        prog_rd,
    output logic        prog_ack,
    output logic        prog_dst,
    output logic        prog_dok,
    output logic        prog_rdy
);
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_LATENCY = 2'd1;
    localparam logic [1:0] c_DATA    = 2'd2;
    localparam logic [1:0] c_WDONE   = 2'd3;

    localparam int              CW           = $clog2(LAT + BURST + 1);
    localparam logic [CW-1:0]   c_LAT_LAST   = CW'(LAT - 1);
    localparam logic [CW-1:0]   c_BURST_LAST = CW'(BURST - 1);
    localparam int              DEPTH        = 4 * (2 ** AW);

    // All four banks share one array; the bank number forms the top index bits
    logic [15:0]   r_mem [0:DEPTH-1];

    logic [1:0]    r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [1:0]    r_rr;
    logic [1:0]    r_bank;
    logic [AW-1:0] r_addr;
    logic          r_prog, r_wr;
    logic [3:0]    r_ack, r_dst, r_dok, r_rdy;
    logic          r_prog_ack, r_prog_dst, r_prog_dok, r_prog_rdy;
    logic [15:0]   r_data;

    logic          w_bank_req, w_prog_req, w_start;
    logic [1:0]    w_bank_sel;
    logic [21:0]   w_bank_addr;
    logic [1:0]    w_new_bank;
    logic [AW-1:0] w_new_addr;
    logic          w_new_wr;
    logic [15:0]   w_new_din;
    logic [1:0]    w_new_mask;
    logic [3:0]    w_ack_nx, w_bank_1hot;
    logic          w_prog_ack_nx, w_dst_any, w_dok_any, w_rdy_any;
    logic [AW+1:0] w_rd_idx, w_wr_idx;

    // Address bits above AW-1 alias and are deliberately dropped
    logic w_unused;
    assign w_unused = ^{ba0_addr[21:AW], ba1_addr[21:AW], ba2_addr[21:AW],
                        ba3_addr[21:AW], prog_addr[21:AW]};

    // Round-robin search: first requesting bank at or after the rr pointer
    always_comb begin
        logic [1:0] v_idx;
        w_bank_req = 1'b0;
        w_bank_sel = r_rr;
        v_idx      = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            v_idx = r_rr + 2'(i);
            if (ba_rd[v_idx]) begin
                w_bank_req = 1'b1;
                w_bank_sel = v_idx;
            end
        end
    end

    // Request fields of the candidate transaction (prog wins over the banks)
    always_comb begin
        case (w_bank_sel)
            2'd0:    w_bank_addr = ba0_addr;
            2'd1:    w_bank_addr = ba1_addr;
            2'd2:    w_bank_addr = ba2_addr;
            default: w_bank_addr = ba3_addr;
        endcase
        w_prog_req = prog_we | prog_rd;
        w_new_bank = w_prog_req ? prog_ba : w_bank_sel;
        w_new_addr = w_prog_req ? prog_addr[AW-1:0] : w_bank_addr[AW-1:0];
        w_new_wr   = w_prog_req ? prog_we : (ba_wr && (w_bank_sel == 2'd0));
        w_new_din  = w_prog_req ? prog_data : ba0_din;
        w_new_mask = w_prog_req ? prog_mask : ba0_din_m;
        w_wr_idx   = {w_new_bank, w_new_addr};
    end

    // Next-state logic; the latency count starts in the ack cycle
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_start    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_prog_req || w_bank_req) begin
                    w_start    = 1'b1;
                    w_state_nx = c_LATENCY;
                    w_cnt_nx   = '0;
                end
            end
            c_LATENCY: begin
                if (r_cnt == c_LAT_LAST) begin
                    w_state_nx = r_wr ? c_WDONE : c_DATA;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            c_DATA: begin
                if (r_cnt == c_BURST_LAST) begin
                    w_state_nx = c_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = c_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Next values of the handshake outputs, derived from the upcoming state
    always_comb begin
        w_ack_nx      = 4'd0;
        w_prog_ack_nx = 1'b0;
        w_dst_any     = 1'b0;
        w_dok_any     = 1'b0;
        w_rdy_any     = 1'b0;
        if (w_start) begin
            if (w_prog_req) w_prog_ack_nx = 1'b1;
            else            w_ack_nx      = 4'd1 << w_bank_sel;
        end
        if (w_state_nx == c_DATA) begin
            w_dok_any = 1'b1;
            w_dst_any = (w_cnt_nx == '0);
            w_rdy_any = (w_cnt_nx == c_BURST_LAST);
        end
        if (w_state_nx == c_WDONE) w_rdy_any = 1'b1;
        w_bank_1hot = 4'd1 << r_bank;
        w_rd_idx    = {r_bank, r_addr + AW'(w_cnt_nx)};
    end

    // State, capture and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_rr       <= 2'd0;
            r_bank     <= 2'd0;
            r_addr     <= '0;
            r_prog     <= 1'b0;
            r_wr       <= 1'b0;
            r_ack      <= 4'd0;
            r_dst      <= 4'd0;
            r_dok      <= 4'd0;
            r_rdy      <= 4'd0;
            r_prog_ack <= 1'b0;
            r_prog_dst <= 1'b0;
            r_prog_dok <= 1'b0;
            r_prog_rdy <= 1'b0;
            r_data     <= 16'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_start) begin
                r_prog <= w_prog_req;
                r_bank <= w_new_bank;
                r_addr <= w_new_addr;
                r_wr   <= w_new_wr;
                if (!w_prog_req) r_rr <= w_bank_sel + 2'd1;
            end
            r_ack      <= w_ack_nx;
            r_prog_ack <= w_prog_ack_nx;
            r_dst      <= (w_dst_any && !r_prog) ? w_bank_1hot : 4'd0;
            r_dok      <= (w_dok_any && !r_prog) ? w_bank_1hot : 4'd0;
            r_rdy      <= (w_rdy_any && !r_prog) ? w_bank_1hot : 4'd0;
            r_prog_dst <= w_dst_any && r_prog;
            r_prog_dok <= w_dok_any && r_prog;
            r_prog_rdy <= w_rdy_any && r_prog;
            if (w_dok_any) r_data <= r_mem[w_rd_idx];
        end
    end

    // Byte-masked write, committed on the edge that accepts the request
    always_ff @(posedge clk) begin
        if (!rst && w_start && w_new_wr) begin
            if (!w_new_mask[0]) r_mem[w_wr_idx][7:0]  <= w_new_din[7:0];
            if (!w_new_mask[1]) r_mem[w_wr_idx][15:8] <= w_new_din[15:8];
        end
    end

    assign ba_ack    = r_ack;
    assign ba_dst    = r_dst;
    assign ba_dok    = r_dok;
    assign ba_rdy    = r_rdy;
    assign prog_ack  = r_prog_ack;
    assign prog_dst  = r_prog_dst;
    assign prog_dok  = r_prog_dok;
    assign prog_rdy  = r_prog_rdy;
    assign data_read = r_data;

endmodule
`default_nettype wire

// File: tb/tb_jtkunio_bram_sdram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtkunio_bram_sdram
//  Purpose  : Self-checking bench for jtkunio_bram_sdram: vector table,
//             hand-written corner sequences and random traffic against a
//             word-level memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtkunio_bram_sdram;
    localparam int AW    = 15;
    localparam int LAT   = 2;
    localparam int BURST = 2;
    localparam int ASZ   = 1 << AW;

    logic        clk, rst;
    logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
    logic [3:0]  ba_rd;
    logic        ba_wr;
    logic [15:0] ba0_din;
    logic [1:0]  ba0_din_m;
    logic [3:0]  ba_ack, ba_dst, ba_dok, ba_rdy;
    logic [15:0] data_read;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask, prog_ba;
    logic        prog_we, prog_rd;
    logic        prog_ack, prog_dst, prog_dok, prog_rdy;

    jtkunio_bram_sdram #(.AW(AW), .LAT(LAT), .BURST(BURST)) dut (
        .clk(clk), .rst(rst),
        .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
        .ba_rd(ba_rd), .ba_wr(ba_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
        .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
        .data_read(data_read),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_ba(prog_ba), .prog_we(prog_we), .prog_rd(prog_rd),
        .prog_ack(prog_ack), .prog_dst(prog_dst), .prog_dok(prog_dok), .prog_rdy(prog_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_pass, n_total, viol;
    logic [15:0] mdl [int];          // key = bank*2^AW + word address
    int          g_ack_k, g_dst_k, g_rdy_k, g_ndok;
    logic [15:0] g_words [4];

    typedef struct {
        bit          is_prog;
        logic [1:0]  bank;
        bit          wr;
        logic [21:0] addr;
        logic [15:0] din;
        logic [1:0]  mask;
        bit          chk_rd;
        logic [15:0] e0, e1;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Handshake exclusivity across all banks and prog
    always @(negedge clk) begin
        if (!rst) begin
            if ($countones({ba_ack, prog_ack}) > 1 || $countones({ba_dst, prog_dst}) > 1 ||
                $countones({ba_dok, prog_dok}) > 1 || $countones({ba_rdy, prog_rdy}) > 1)
                viol++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic clear_inputs();
        ba0_addr = '0; ba1_addr = '0; ba2_addr = '0; ba3_addr = '0;
        ba_rd = '0; ba_wr = 1'b0; ba0_din = '0; ba0_din_m = '0;
        prog_addr = '0; prog_data = '0; prog_mask = '0; prog_ba = '0;
        prog_we = 1'b0; prog_rd = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One request from the requester side; records event offsets from the request cycle
    task automatic xfer(input bit is_prog, input logic [1:0] bank, input bit wr,
                        input logic [21:0] addr, input logic [15:0] din, input logic [1:0] mask);
        int k;
        bit done;
        @(negedge clk);
        if (is_prog) begin
            prog_addr = addr; prog_data = din; prog_mask = mask; prog_ba = bank;
            prog_we = wr; prog_rd = !wr;
        end else begin
            case (bank)
                2'd0: ba0_addr = addr;
                2'd1: ba1_addr = addr;
                2'd2: ba2_addr = addr;
                default: ba3_addr = addr;
            endcase
            ba_wr = wr; ba0_din = din; ba0_din_m = mask;
            ba_rd = 4'd1 << bank;
        end
        g_ack_k = -1; g_dst_k = -1; g_rdy_k = -1; g_ndok = 0; k = 0; done = 0;
        for (int j = 0; j < 4; j++) g_words[j] = 16'h0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
            if ((is_prog ? prog_ack : ba_ack[bank]) && g_ack_k < 0) begin
                g_ack_k = k;
                prog_we = 1'b0; prog_rd = 1'b0; ba_rd = 4'd0;
                // scramble every request field: the transaction must use captured values
                ba0_addr = ~ba0_addr; ba1_addr = ~ba1_addr; ba2_addr = ~ba2_addr;
                ba3_addr = ~ba3_addr; prog_addr = ~prog_addr; ba0_din = ~ba0_din;
                prog_data = ~prog_data; ba0_din_m = ~ba0_din_m; prog_mask = ~prog_mask;
                ba_wr = ~ba_wr; prog_ba = ~prog_ba;
            end
            if ((is_prog ? prog_dst : ba_dst[bank]) && g_dst_k < 0) g_dst_k = k;
            if (is_prog ? prog_dok : ba_dok[bank]) begin
                if (g_ndok < 4) g_words[g_ndok] = data_read;
                g_ndok++;
            end
            if (is_prog ? prog_rdy : ba_rdy[bank]) begin
                g_rdy_k = k;
                done = 1;
            end
        end
        prog_we = 1'b0; prog_rd = 1'b0; ba_rd = 4'd0; ba_wr = 1'b0;
    endtask

    // Run one transaction, check its timing and data against the model, then update the model
    task automatic do_op(input string name, input bit is_prog, input logic [1:0] bank, input bit wr,
                         input logic [21:0] addr, input logic [15:0] din, input logic [1:0] mask);
        bit          weff;
        int          base, key;
        logic [31:0] sig, exp_sig;
        logic [15:0] old;
        weff = is_prog ? wr : (wr && bank == 2'd0);
        xfer(is_prog, bank, wr, addr, din, mask);
        sig = {8'(g_ack_k), 8'(g_dst_k), 8'(g_rdy_k), 8'(g_ndok)};
        if (weff) exp_sig = {8'd1, 8'hFF, 8'(1 + LAT), 8'd0};
        else      exp_sig = {8'd1, 8'(1 + LAT), 8'(LAT + BURST), 8'(BURST)};
        chk({name, "/timing"}, sig, exp_sig);
        base = int'(bank) * ASZ;
        if (weff) begin
            key = base + int'(addr[AW-1:0]);
            if (mask == 2'b00) mdl[key] = din;
            else if (mask != 2'b11) begin
                if (mdl.exists(key)) begin
                    old = mdl[key];
                    if (!mask[0]) old[7:0]  = din[7:0];
                    if (!mask[1]) old[15:8] = din[15:8];
                    mdl[key] = old;
                end else begin
                    mdl.delete(key);
                end
            end
        end else begin
            for (int j = 0; j < BURST; j++) begin
                key = base + ((int'(addr[AW-1:0]) + j) % ASZ);
                if (mdl.exists(key)) chk($sformatf("%s/word%0d", name, j), g_words[j], mdl[key]);
            end
        end
    endtask

    // Hold all four ba_rd bits, drop each on its ack, and record the service order
    task automatic rr_pass(output logic [7:0] order, output int nack);
        int k, nrdy;
        order = 8'd0; nack = 0; nrdy = 0; k = 0;
        @(negedge clk);
        ba_wr = 1'b0;
        ba0_addr = 22'h100; ba1_addr = 22'h100; ba2_addr = 22'h100; ba3_addr = 22'h100;
        ba_rd = 4'b1111;
        while (nrdy < 4 && k < 100) begin
            @(negedge clk);
            k++;
            if (ba_ack != 4'd0) begin
                for (int b = 0; b < 4; b++) begin
                    if (ba_ack[b]) begin
                        if (nack < 4) order[7 - 2*nack -: 2] = 2'(b);
                        nack++;
                    end
                end
                ba_rd = ba_rd & ~ba_ack;
            end
            if (ba_rdy != 4'd0) nrdy++;
        end
        ba_rd = 4'd0;
    endtask

    initial begin
        logic [7:0]  order;
        int          nack, k, pa, pr, b2, nr;
        logic [15:0] pw0;
        logic [21:0] ra;

        n_pass = 0; n_total = 0; viol = 0;
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ack",  {ba_ack, prog_ack}, 32'd0);
        chk("rst_dst",  {ba_dst, prog_dst}, 32'd0);
        chk("rst_dok",  {ba_dok, prog_dok}, 32'd0);
        chk("rst_rdy",  {ba_rdy, prog_rdy}, 32'd0);
        chk("rst_data", data_read, 32'd0);
        rst = 1'b0;

        // Download a word, then read it back through bank 1
        do_op("tp1_wr",  1, 2'd1, 1, 22'h10, 16'hBEEF, 2'b00);
        do_op("tp1_wr2", 1, 2'd1, 1, 22'h11, 16'h4242, 2'b00);
        do_op("tp1_rd",  0, 2'd1, 0, 22'h10, 16'h0, 2'b00);
        chk("tp1_w0", g_words[0], 16'hBEEF);
        chk("tp1_w1", g_words[1], 16'h4242);

        tbl[0]  = '{1'b1, 2'd0, 1'b1, 22'h000040, 16'hA5A5, 2'b00, 1'b0, 16'h0,    16'h0};
        tbl[1]  = '{1'b1, 2'd0, 1'b1, 22'h000041, 16'h5A5A, 2'b00, 1'b0, 16'h0,    16'h0};
        tbl[2]  = '{1'b0, 2'd0, 1'b1, 22'h000040, 16'h1234, 2'b01, 1'b0, 16'h0,    16'h0};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 22'h000040, 16'h0000, 2'b00, 1'b1, 16'h12A5, 16'h5A5A};
        tbl[4]  = '{1'b1, 2'd1, 1'b1, 22'h000040, 16'h7777, 2'b00, 1'b0, 16'h0,    16'h0};
        tbl[5]  = '{1'b1, 2'd1, 1'b1, 22'h000041, 16'h8888, 2'b00, 1'b0, 16'h0,    16'h0};
        tbl[6]  = '{1'b0, 2'd1, 1'b1, 22'h000040, 16'hFFFF, 2'b00, 1'b1, 16'h7777, 16'h8888};
        tbl[7]  = '{1'b1, 2'd2, 1'b1, 22'h000040, 16'hC0DE, 2'b00, 1'b0, 16'h0,    16'h0};
        tbl[8]  = '{1'b1, 2'd2, 1'b1, 22'h000041, 16'h0F0F, 2'b00, 1'b0, 16'h0,    16'h0};
        tbl[9]  = '{1'b1, 2'd2, 1'b0, 22'h000040, 16'h0000, 2'b00, 1'b1, 16'hC0DE, 16'h0F0F};
        tbl[10] = '{1'b0, 2'd2, 1'b0, 22'h200040, 16'h0000, 2'b00, 1'b1, 16'hC0DE, 16'h0F0F};
        tbl[11] = '{1'b1, 2'd0, 1'b1, 22'h000041, 16'h0000, 2'b11, 1'b0, 16'h0,    16'h0};
        tbl[12] = '{1'b1, 2'd0, 1'b0, 22'h000040, 16'h0000, 2'b00, 1'b1, 16'h12A5, 16'h5A5A};
        for (int i = 0; i < 13; i++) begin
            do_op($sformatf("vec%0d", i), tbl[i].is_prog, tbl[i].bank, tbl[i].wr,
                  tbl[i].addr, tbl[i].din, tbl[i].mask);
            if (tbl[i].chk_rd) begin
                chk($sformatf("vec%0d_e0", i), g_words[0], tbl[i].e0);
                chk($sformatf("vec%0d_e1", i), g_words[1], tbl[i].e1);
            end
        end

        // Bank 0 write with upper byte masked
        do_op("mask_pre0", 1, 2'd0, 1, 22'h200, 16'h5566, 2'b00);
        do_op("mask_pre1", 1, 2'd0, 1, 22'h201, 16'h9999, 2'b00);
        do_op("mask_wr",   0, 2'd0, 1, 22'h200, 16'h1234, 2'b10);
        do_op("mask_rd",   0, 2'd0, 0, 22'h200, 16'h0, 2'b00);
        chk("mask_w0", g_words[0], 16'h5534);

        // Burst wrap at the top of the bank and upper-bit aliasing
        do_op("wrap_p0", 1, 2'd3, 1, 22'h7FFF, 16'h1111, 2'b00);
        do_op("wrap_p1", 1, 2'd3, 1, 22'h0000, 16'h2222, 2'b00);
        do_op("wrap_p2", 1, 2'd3, 1, 22'h0001, 16'h3333, 2'b00);
        do_op("wrap_rd", 0, 2'd3, 0, 22'h7FFF, 16'h0, 2'b00);
        chk("wrap_w1", g_words[1], 16'h2222);
        do_op("alias_rd", 0, 2'd3, 0, 22'h8000, 16'h0, 2'b00);
        chk("alias_w0", g_words[0], 16'h2222);

        // prog and bank 2 requested together: prog first, bank 2 right after
        @(negedge clk);
        prog_ba = 2'd1; prog_addr = 22'h10; prog_rd = 1'b1;
        ba2_addr = 22'h40; ba_wr = 1'b0; ba_rd = 4'b0100;
        pa = -1; pr = -1; b2 = -1; k = 0; nr = 0; pw0 = 16'h0;
        while (nr < 2 && k < 60) begin
            @(negedge clk);
            k++;
            if (prog_ack && pa < 0) begin pa = k; prog_rd = 1'b0; end
            if (ba_ack[2] && b2 < 0) begin b2 = k; ba_rd = 4'd0; end
            if (prog_dst) pw0 = data_read;
            if (prog_rdy && pr < 0) pr = k;
            if (prog_rdy || ba_rdy != 4'd0) nr++;
        end
        prog_rd = 1'b0; ba_rd = 4'd0;
        chk("prio_prog_ack", pa, 1);
        chk("prio_prog_rdy", pr, LAT + BURST);
        chk("prio_prog_w0", pw0, 16'hBEEF);
        chk("prio_b2_after", (b2 > pr && b2 <= pr + 2), 1);

        // Round robin from a fresh pointer, then from pointer 3
        do_reset();
        rr_pass(order, nack);
        chk("rr1_order", order, 8'b00_01_10_11);
        chk("rr1_nack", nack, 4);
        do_op("rr_b2", 0, 2'd2, 0, 22'h40, 16'h0, 2'b00);
        rr_pass(order, nack);
        chk("rr2_order", order, 8'b11_00_01_10);
        chk("rr2_nack", nack, 4);

        // Reset during the data phase aborts the read without rdy
        @(negedge clk);
        ba1_addr = 22'h10; ba_wr = 1'b0; ba_rd = 4'b0010;
        k = 0;
        while (!ba_dst[1] && k < 40) begin
            @(negedge clk);
            k++;
            if (ba_ack[1]) ba_rd = 4'd0;
        end
        chk("rstmid_dst_seen", ba_dst[1], 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_out", {ba_ack, ba_dst, ba_dok, ba_rdy, prog_ack, prog_dst, prog_dok, prog_rdy}, 32'd0);
        chk("rstmid_data", data_read, 32'd0);
        rst = 1'b0;
        nr = 0;
        repeat (6) begin
            @(negedge clk);
            if (ba_rdy != 4'd0 || ba_dok != 4'd0) nr++;
        end
        chk("rstmid_quiet", nr, 0);
        do_op("rstmid_redo", 0, 2'd1, 0, 22'h10, 16'h0, 2'b00);
        chk("rstmid_w0", g_words[0], 16'hBEEF);

        // Random traffic over a small preloaded window, with random upper address bits
        for (int b = 0; b < 4; b++)
            for (int a = 16'h100; a <= 16'h10A; a++)
                do_op("pre", 1, 2'(b), 1, 22'(a), 16'($urandom), 2'b00);
        for (int i = 0; i < 60; i++) begin
            ra = 22'($urandom);
            ra[AW-1:0] = AW'(16'h100 + $urandom_range(0, 9));
            do_op($sformatf("rnd%0d", i), ($urandom_range(0, 2) == 0), 2'($urandom),
                  1'($urandom), ra, 16'($urandom), 2'($urandom));
        end

        chk("onehot_viol", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
